// File: rtl/store_buffer.sv
// Posted-write store buffer: in-order drain to memory over req/ack, with
// youngest-match load snooping over the registered entries.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         st_valid,
  input  logic [ADDR_W-1:0]            st_addr,
  input  logic [DATA_W-1:0]            st_data,
  output logic                         st_ready,
  input  logic                         ld_valid,
  input  logic [ADDR_W-1:0]            ld_addr,
  output logic                         ld_hit,
  output logic [DATA_W-1:0]            ld_data,
  output logic                         mem_req,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic                         mem_ack,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IDX_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  match;
  logic [IDX_W-1:0]  idx;
  logic              push;
  logic              pop;
  logic              unused_ld_low;

  assign unused_ld_low = ^ld_addr[1:0];

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign st_ready  = (count < CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign mem_req   = !empty;
  assign push      = st_valid && st_ready;
  assign pop       = mem_req && mem_ack;
  // Gate the head outputs so an idle port never shows a stale entry.
  assign mem_addr  = mem_req ? addr_mem[rd_ptr] : '0;
  assign mem_wdata = mem_req ? data_mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      addr_mem[wr_ptr] <= st_addr;
      data_mem[wr_ptr] <= st_data;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign match[gi] = (addr_mem[gi][ADDR_W-1:2] == ld_addr[ADDR_W-1:2]);
  end

  // Walk entries oldest to youngest so the last valid match is the youngest.
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = '0;
    idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = {1'b0, rd_ptr} + IDX_W'(k);
      if (idx >= IDX_W'(DEPTH)) idx = idx - IDX_W'(DEPTH);
      if (ld_valid && (CNT_W'(k) < count) && match[idx[PTR_W-1:0]]) begin
        ld_hit  = 1'b1;
        ld_data = data_mem[idx[PTR_W-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboarded bench for store_buffer: directed scenarios then random traffic,
// checked against a queue-based model of the buffer contents.
module tb_store_buffer;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [2:0]  count;
  logic        empty;

  int compared   = 0;
  int mismatched = 0;

  entry_t model[$];   // architectural contents, oldest first
  entry_t exp_q[$];   // expected drain sequence for the monitor

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .count(count), .empty(empty)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    logic        hit;
    logic [31:0] data;
    chk("st_ready", {31'd0, st_ready}, {31'd0, model.size() < DEPTH});
    chk("count", {29'd0, count}, model.size());
    chk("empty", {31'd0, empty}, {31'd0, model.size() == 0});
    chk("mem_req", {31'd0, mem_req}, {31'd0, model.size() != 0});
    if (model.size() != 0) begin
      chk("head_addr", mem_addr, model[0].addr);
      chk("head_data", mem_wdata, model[0].data);
    end
    hit  = 1'b0;
    data = '0;
    if (ld_valid) begin
      foreach (model[i]) begin
        if (model[i].addr[31:2] == ld_addr[31:2]) begin
          hit  = 1'b1;
          data = model[i].data;
        end
      end
    end
    chk("ld_hit", {31'd0, ld_hit}, {31'd0, hit});
    chk("ld_data", ld_data, data);
  endtask

  // One clock: drive inputs, check pre-edge state at negedge, advance the model.
  task automatic cycle(input logic rst, input logic sv, input logic [31:0] sa,
                       input logic [31:0] sd, input logic lv, input logic [31:0] la,
                       input logic ack);
    entry_t e;
    bit     can_push;
    rst_n = rst; st_valid = sv; st_addr = sa; st_data = sd;
    ld_valid = lv; ld_addr = la; mem_ack = ack;
    @(negedge clk);
    check_state();
    if (!rst) begin
      model.delete();
      exp_q.delete();
    end else begin
      can_push = model.size() < DEPTH;
      if (ack && model.size() != 0) void'(model.pop_front());
      if (sv && can_push) begin
        e.addr = sa;
        e.data = sd;
        model.push_back(e);
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && model.size() != 0; i++)
      cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
  endtask

  // Monitor: every accepted memory write must be the next expected store.
  initial begin
    entry_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && mem_req === 1'b1 && mem_ack === 1'b1) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL drain_extra: got addr %h expected no request", mem_addr);
        end else begin
          e = exp_q.pop_front();
          $display("drain addr=%h data=%h", mem_addr, mem_wdata);
          chk("drain_addr", mem_addr, e.addr);
          chk("drain_data", mem_wdata, e.data);
        end
      end
    end
  end

  initial begin
    int issued;
    bit will;
    logic [31:0] a;
    // 1: reset held with a store presented
    cycle(1'b0, 1'b1, 32'h100, 32'h1, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 32'h100, 32'h1, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    // 2: fill, then a held 5th store is refused
    cycle(1'b1, 1'b1, 32'h10, 32'hA, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 32'h14, 32'hB, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 32'h18, 32'hC, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 32'h1C, 32'hD, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 32'h20, 32'hE, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 32'h20, 32'hE, 1'b0, 32'h0, 1'b0);
    // 3: drain back-to-back
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    // 4: youngest match, word granularity, same-cycle push invisible
    cycle(1'b1, 1'b1, 32'h20, 32'h11, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 32'h20, 32'h22, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h20, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h22, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h24, 1'b0);
    cycle(1'b1, 1'b1, 32'h30, 32'h33, 1'b1, 32'h30, 1'b0);
    // 5: push while popping at count 2
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h20, 1'b1);
    cycle(1'b1, 1'b1, 32'h40, 32'h44, 1'b1, 32'h30, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    drain(10);
    // 6: stream 10 stores with alternating ack
    issued = 0;
    for (int c = 0; c < 100 && issued < 10; c++) begin
      will = model.size() < DEPTH;
      cycle(1'b1, 1'b1, 32'h200 + 32'(issued * 4), 32'h500 + 32'(issued), 1'b0, 32'h0, c[0] == 1'b0);
      if (will) issued++;
    end
    chk("stream_issued", issued, 10);
    for (int c = 0; c < 40 && model.size() != 0; c++)
      cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, c[0] == 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    // 7: reset mid-drain
    cycle(1'b1, 1'b1, 32'h60, 32'h6, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 32'h64, 32'h7, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 32'h68, 32'h8, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h64, 1'b1);
    // Random traffic over a small address pool to provoke aliasing
    for (int i = 0; i < 400; i++) begin
      a = 32'h80 + 32'($urandom_range(0, 5)) * 4;
      cycle($urandom_range(0, 99) != 0, 1'($urandom_range(0, 1)), a, $urandom,
            1'($urandom_range(0, 1)), 32'h80 + 32'($urandom_range(0, 23)),
            1'($urandom_range(0, 2) != 0));
    end
    drain(20);
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("drain_leftover", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
